// File: rtl/wave_instr_feeder.sv
// wave_instr_feeder: buffers fetched instruction pairs and feeds low/high dwords to decode
module wave_instr_feeder #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [5:0]       fetch_wfid,
  input  logic [31:0]      fetch_pc,
  input  logic [63:0]      fetch_instr,
  input  logic [8:0]       fetch_sgpr_base,
  input  logic [9:0]       fetch_vgpr_base,
  input  logic [15:0]      fetch_lds_base,
  input  logic             feeder_hold,
  input  logic             feeder_flush,
  input  logic             wave_ins_half_rqd,
  input  logic [5:0]       wave_ins_half_wfid,
  output logic             wave_instr_valid,
  output logic [31:0]      wave_instr,
  output logic [31:0]      wave_instr_pc,
  output logic [5:0]       wave_wfid,
  output logic [8:0]       wave_sgpr_base,
  output logic [9:0]       wave_vgpr_base,
  output logic [15:0]      wave_lds_base,
  output logic             feeder_half_err,
  output logic [PTR_W:0]   feeder_count
);
  typedef enum logic [1:0] {IDLE, WAIT, HI} state_t;
  state_t state, state_nx;
  logic [5:0]       m_wfid  [DEPTH];
  logic [31:0]      m_pc    [DEPTH];
  logic [63:0]      m_instr [DEPTH];
  logic [8:0]       m_sgpr  [DEPTH];
  logic [9:0]       m_vgpr  [DEPTH];
  logic [15:0]      m_lds   [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, launch, hi_go, err_set;
  assign fetch_ready  = count != (PTR_W+1)'(DEPTH);
  assign feeder_count = count;
  assign push         = fetch_valid & fetch_ready & ~feeder_flush;
  // storage has no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      m_wfid[wr_ptr]  <= fetch_wfid;
      m_pc[wr_ptr]    <= fetch_pc;
      m_instr[wr_ptr] <= fetch_instr;
      m_sgpr[wr_ptr]  <= fetch_sgpr_base;
      m_vgpr[wr_ptr]  <= fetch_vgpr_base;
      m_lds[wr_ptr]   <= fetch_lds_base;
    end
  end
  // next state: launch low dword, answer half request, flush overrides everything
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    hi_go    = 1'b0;
    err_set  = 1'b0;
    pop      = 1'b0;
    if (feeder_flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE: begin
          launch   = (count != '0) && !feeder_hold;
          err_set  = wave_ins_half_rqd;
          state_nx = launch ? WAIT : IDLE;
        end
        WAIT: begin
          pop      = 1'b1;
          hi_go    = wave_ins_half_rqd && (wave_ins_half_wfid == m_wfid[rd_ptr]);
          err_set  = wave_ins_half_rqd && !hi_go;
          state_nx = hi_go ? HI : IDLE;
        end
        default: begin
          err_set  = wave_ins_half_rqd;
          state_nx = IDLE;
        end
      endcase
    end
  end
  // state, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (feeder_flush) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
  // registered decode outputs; data holds while valid is low, error is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_instr_valid <= 1'b0;
      wave_instr       <= '0;
      wave_instr_pc    <= '0;
      wave_wfid        <= '0;
      wave_sgpr_base   <= '0;
      wave_vgpr_base   <= '0;
      wave_lds_base    <= '0;
      feeder_half_err  <= 1'b0;
    end else begin
      wave_instr_valid <= launch | hi_go;
      feeder_half_err  <= feeder_half_err | err_set;
      if (launch | hi_go) begin
        wave_instr     <= hi_go ? m_instr[rd_ptr][63:32] : m_instr[rd_ptr][31:0];
        wave_instr_pc  <= hi_go ? m_pc[rd_ptr] + 32'd4 : m_pc[rd_ptr];
        wave_wfid      <= m_wfid[rd_ptr];
        wave_sgpr_base <= m_sgpr[rd_ptr];
        wave_vgpr_base <= m_vgpr[rd_ptr];
        wave_lds_base  <= m_lds[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_wave_instr_feeder.sv
// tb_wave_instr_feeder: random and directed stimulus against a queue-based reference model
module tb_wave_instr_feeder;
  logic        clk = 0, rst = 1;
  logic        fetch_valid = 0, fetch_ready;
  logic [5:0]  fetch_wfid = 0;
  logic [31:0] fetch_pc = 0;
  logic [63:0] fetch_instr = 0;
  logic [8:0]  fetch_sgpr_base = 0;
  logic [9:0]  fetch_vgpr_base = 0;
  logic [15:0] fetch_lds_base = 0;
  logic        feeder_hold = 0, feeder_flush = 0, wave_ins_half_rqd = 0;
  logic [5:0]  wave_ins_half_wfid = 0;
  logic        wave_instr_valid, feeder_half_err;
  logic [31:0] wave_instr, wave_instr_pc;
  logic [5:0]  wave_wfid;
  logic [8:0]  wave_sgpr_base;
  logic [9:0]  wave_vgpr_base;
  logic [15:0] wave_lds_base;
  logic [2:0]  feeder_count;
  int checks = 0, errors = 0;

  wave_instr_feeder #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_wfid(fetch_wfid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_sgpr_base(fetch_sgpr_base), .fetch_vgpr_base(fetch_vgpr_base),
    .fetch_lds_base(fetch_lds_base), .feeder_hold(feeder_hold), .feeder_flush(feeder_flush),
    .wave_ins_half_rqd(wave_ins_half_rqd), .wave_ins_half_wfid(wave_ins_half_wfid),
    .wave_instr_valid(wave_instr_valid), .wave_instr(wave_instr), .wave_instr_pc(wave_instr_pc),
    .wave_wfid(wave_wfid), .wave_sgpr_base(wave_sgpr_base), .wave_vgpr_base(wave_vgpr_base),
    .wave_lds_base(wave_lds_base), .feeder_half_err(feeder_half_err), .feeder_count(feeder_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  typedef struct {
    logic [5:0] wfid; logic [31:0] pc; logic [63:0] ins;
    logic [8:0] s; logic [9:0] v; logic [15:0] l;
  } ent_t;
  ent_t q[$];
  int          phase = 0;
  logic        e_valid = 0, e_err = 0;
  logic [31:0] e_instr = 0, e_pc = 0;
  logic [5:0]  e_wfid = 0;
  logic [8:0]  e_s = 0;
  logic [9:0]  e_v = 0;
  logic [15:0] e_l = 0;

  task automatic emit(input ent_t e, input bit hi);
    e_valid = 1;
    e_instr = hi ? e.ins[63:32] : e.ins[31:0];
    e_pc    = hi ? e.pc + 32'd4 : e.pc;
    e_wfid  = e.wfid; e_s = e.s; e_v = e.v; e_l = e.l;
  endtask

  // phase: 0 = nothing outstanding, 1 = low dword just shown, 2 = high dword just shown
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); phase = 0; e_valid = 0; e_err = 0;
      e_instr = 0; e_pc = 0; e_wfid = 0; e_s = 0; e_v = 0; e_l = 0;
    end else begin
      automatic bit   pu = fetch_valid && q.size() != 4 && !feeder_flush;
      automatic ent_t ne = '{fetch_wfid, fetch_pc, fetch_instr, fetch_sgpr_base,
                             fetch_vgpr_base, fetch_lds_base};
      if (feeder_flush) begin
        q.delete(); phase = 0; e_valid = 0;
      end else begin
        e_valid = 0;
        if (phase == 0) begin
          if (wave_ins_half_rqd) e_err = 1;
          if (q.size() != 0 && !feeder_hold) begin emit(q[0], 0); phase = 1; end
        end else if (phase == 1) begin
          automatic ent_t h = q.pop_front();
          phase = 0;
          if (wave_ins_half_rqd && wave_ins_half_wfid == h.wfid) begin emit(h, 1); phase = 2; end
          else if (wave_ins_half_rqd) e_err = 1;
        end else begin
          if (wave_ins_half_rqd) e_err = 1;
          phase = 0;
        end
        if (pu) q.push_back(ne);
      end
    end
    #1;
    if (!rst) begin
      chk("valid", wave_instr_valid, e_valid);
      chk("instr", wave_instr, e_instr);
      chk("pc", wave_instr_pc, e_pc);
      chk("wfid", wave_wfid, e_wfid);
      chk("bases", {wave_sgpr_base, wave_vgpr_base, wave_lds_base}, {e_s, e_v, e_l});
      chk("half_err", feeder_half_err, e_err);
      chk("count", feeder_count, q.size());
      chk("ready", fetch_ready, q.size() != 4);
    end
  end

  task automatic set_fetch(input logic [5:0] w, input logic [31:0] pc, input logic [63:0] ins);
    fetch_valid = 1; fetch_wfid = w; fetch_pc = pc; fetch_instr = ins;
    fetch_sgpr_base = 9'($urandom); fetch_vgpr_base = 10'($urandom); fetch_lds_base = 16'($urandom);
  endtask

  task automatic push_one(input logic [5:0] w, input logic [31:0] pc, input logic [63:0] ins);
    int n = 0;
    set_fetch(w, pc, ins);
    while (!fetch_ready && n < 50) begin @(negedge clk); n++; end
    if (!fetch_ready) chk("push_timeout", 1, 0);
    @(negedge clk);
    fetch_valid = 0;
  endtask

  task automatic wait_pulse(input string n);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (!wave_instr_valid && k < 30);
    if (!wave_instr_valid) chk({n, "_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_valid", wave_instr_valid, 0);
    chk("rst_ready", fetch_ready, 1);
    chk("rst_count", feeder_count, 0);
    chk("rst_instr", wave_instr, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    // single 32-bit instruction, no half request
    push_one(6'd37, 32'hcafe_0000, {32'h0, 32'hBE82_0707});
    wait_pulse("t1");
    chk("t1_instr", wave_instr, 32'hBE82_0707);
    chk("t1_pc", wave_instr_pc, 32'hcafe_0000);
    chk("t1_wfid", wave_wfid, 6'd37);
    idle(3);
    chk("t1_count", feeder_count, 0);
    // 64-bit instruction with matching half request
    push_one(6'd37, 32'hcafe_0000, {32'h1234_5678, 32'hBE82_07FF});
    wait_pulse("t2");
    wave_ins_half_rqd = 1; wave_ins_half_wfid = 6'd37;
    @(posedge clk); #1;
    wave_ins_half_rqd = 0;
    chk("t2_valid", wave_instr_valid, 1);
    chk("t2_instr", wave_instr, 32'h1234_5678);
    chk("t2_pc", wave_instr_pc, 32'hcafe_0004);
    idle(3);
    // fill past depth while held
    feeder_hold = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_fetch(6'(i + 1), 32'h100 * i, {$urandom, $urandom});
      @(negedge clk);
    end
    chk("t3_ready", fetch_ready, 0);
    chk("t3_count", feeder_count, 4);
    set_fetch(6'd5, 32'h500, {$urandom, $urandom});
    feeder_hold = 0;
    begin
      int n = 0;
      while (!fetch_ready && n < 20) begin @(negedge clk); n++; end
      chk("t3_fifth_accepted", fetch_ready, 1);
    end
    @(negedge clk);
    fetch_valid = 0;
    idle(15);
    // hold blocks launch until released
    feeder_hold = 1;
    push_one(6'd9, 32'hffff_fffc, {32'hdead_beef, 32'h0bad_f00d});
    idle(4);
    chk("t6_hold_count", feeder_count, 1);
    chk("t6_hold_valid", wave_instr_valid, 0);
    feeder_hold = 0;
    wait_pulse("t6");
    wave_ins_half_rqd = 1; wave_ins_half_wfid = 6'd9;
    @(posedge clk); #1;
    wave_ins_half_rqd = 0;
    chk("t6_wrap_pc", wave_instr_pc, 32'h0);
    chk("t6_hi_instr", wave_instr, 32'hdead_beef);
    idle(3);
    // flush with three queued and a simultaneous push
    feeder_hold = 1;
    for (int i = 0; i < 3; i++) push_one(6'(20 + i), 32'h40 * i, {$urandom, $urandom});
    set_fetch(6'd30, 32'h0, 64'h0);
    feeder_flush = 1;
    @(negedge clk);
    feeder_flush = 0; fetch_valid = 0;
    chk("t5_count", feeder_count, 0);
    chk("t5_valid", wave_instr_valid, 0);
    feeder_hold = 0;
    idle(3);
    chk("t5_dropped", feeder_count, 0);
    // mismatched half request
    push_one(6'd27, 32'h2000, {32'h7777_7777, 32'h6666_6666});
    wait_pulse("t4");
    wave_ins_half_rqd = 1; wave_ins_half_wfid = 6'd12;
    @(posedge clk); #1;
    wave_ins_half_rqd = 0;
    chk("t4_no_hi", wave_instr_valid, 0);
    chk("t4_err", feeder_half_err, 1);
    idle(5);
    chk("t4_err_sticky", feeder_half_err, 1);
    // reset in the middle of a transaction
    push_one(6'd3, 32'h3000, {$urandom, $urandom});
    push_one(6'd4, 32'h3008, {$urandom, $urandom});
    wait_pulse("rst_mid");
    rst = 1;
    #1;
    chk("mid_rst_valid", wave_instr_valid, 0);
    chk("mid_rst_count", feeder_count, 0);
    chk("mid_rst_err", feeder_half_err, 0);
    chk("mid_rst_instr", wave_instr, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      fetch_valid        = $urandom_range(0, 1);
      fetch_wfid         = 6'($urandom_range(0, 7));
      fetch_pc           = $urandom;
      fetch_instr        = {$urandom, $urandom};
      fetch_sgpr_base    = 9'($urandom);
      fetch_vgpr_base    = 10'($urandom);
      fetch_lds_base     = 16'($urandom);
      feeder_hold        = $urandom_range(0, 4) == 0;
      feeder_flush       = $urandom_range(0, 40) == 0;
      if (feeder_flush) wave_ins_half_rqd = 0;
      else if (phase == 1) begin
        wave_ins_half_rqd  = $urandom_range(0, 9) < 6;
        wave_ins_half_wfid = $urandom_range(0, 4) != 0 ? q[0].wfid : 6'($urandom_range(0, 7));
      end else begin
        wave_ins_half_rqd  = $urandom_range(0, 200) == 0;
        wave_ins_half_wfid = 6'($urandom);
      end
      if (c == 1500) begin rst = 1; @(negedge clk); rst = 0; end
      @(negedge clk);
    end
    fetch_valid = 0; feeder_flush = 0; wave_ins_half_rqd = 0; feeder_hold = 0;
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
